patch_scheduler: RTL

//  Sequences the patchifier over a full image: walks the patch grid row-major, has the image buffer load each

---
 rtl/vit_pkg.sv | 24 ++
 rtl/patch_scheduler_if.sv | 43 ++++
 rtl/patch_grid_counter.sv | 56 +++++
 rtl/patch_scheduler.sv | 126 ++++++++++++
 4 files changed

// File: rtl/vit_pkg.sv
// Shared ViT front-end definitions: patchifier state encodings, scheduler FSM states
// and a width helper for the grid counters.
package vit_pkg;

  localparam logic [1:0] PF_IDLE = 2'b00;
  localparam logic [1:0] PF_PROC = 2'b10;
  localparam logic [1:0] PF_DONE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT_PF,
    S_SETTLE,
    S_EMIT,
    S_FINISH
  } sched_state_t;

  // A 1x1 grid still needs a 1-bit counter rather than a zero-width vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/patch_scheduler_if.sv
// Control bundle between the patch scheduler and its neighbours: host start/status,
// image-buffer load request, patchifier control and the embedding-stage handshake.
interface patch_scheduler_if
  import vit_pkg::*;
#(
  parameter int IMG_H = 224,
  parameter int IMG_W = 224,
  parameter int PATCH = 16
);
  localparam int PH = IMG_H / PATCH;
  localparam int PW = IMG_W / PATCH;
  localparam int RW = clog2_min1(PH);
  localparam int CW = clog2_min1(PW);
  localparam int IW = clog2_min1(PH * PW);

  logic          start;
  logic          busy;
  logic          done;
  logic          error;
  logic          load_req;
  logic [RW-1:0] load_row;
  logic [CW-1:0] load_col;
  logic          load_ack;
  logic          pf_en;
  logic [1:0]    pf_state;
  logic          pf_output_taken;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_patch_idx;

  modport master (
    input  start, load_ack, pf_state, out_ready,
    output busy, done, error, load_req, load_row, load_col,
           pf_en, pf_output_taken, out_valid, out_patch_idx
  );

  modport slave (
    output start, load_ack, pf_state, out_ready,
    input  busy, done, error, load_req, load_row, load_col,
           pf_en, pf_output_taken, out_valid, out_patch_idx
  );

endinterface

// File: rtl/patch_grid_counter.sv
// Row-major walker over the PH x PW patch grid; the linear index is carried alongside
// row/col so no multiplier is needed to present it.
module patch_grid_counter
  import vit_pkg::*;
#(
  parameter  int PH = 14,
  parameter  int PW = 14,
  localparam int RW = clog2_min1(PH),
  localparam int CW = clog2_min1(PW),
  localparam int IW = clog2_min1(PH * PW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          step_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic [IW-1:0] idx_o,
  output logic          last_o
);

  localparam logic [RW-1:0] ROW_LAST = RW'(PH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [IW-1:0] idx_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      idx_q <= '0;
    end else if (clear_i) begin
      row_q <= '0;
      col_q <= '0;
      idx_q <= '0;
    end else if (step_i) begin
      idx_q <= idx_q + 1'b1;
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign idx_o  = idx_q;
  assign last_o = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/patch_scheduler.sv
// Walks the patch grid: load tile, kick patchifier, wait for DONE with a timeout,
// then hand the vectorized patch downstream over valid/ready.
module patch_scheduler
  import vit_pkg::*;
#(
  parameter int IMG_H   = 224,
  parameter int IMG_W   = 224,
  parameter int PATCH   = 16,
  parameter int TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset,
  patch_scheduler_if.master bus
);

  localparam int PH = IMG_H / PATCH;
  localparam int PW = IMG_W / PATCH;
  localparam int RW = clog2_min1(PH);
  localparam int CW = clog2_min1(PW);
  localparam int IW = clog2_min1(PH * PW);
  localparam int TW = clog2_min1(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  sched_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          error_q, error_d;
  logic          pf_en_q, pf_en_d;
  logic          busy_q, done_q, load_req_q, out_valid_q;

  logic          grid_clear, grid_step, grid_last;
  logic [RW-1:0] grid_row;
  logic [CW-1:0] grid_col;
  logic [IW-1:0] grid_idx;

  patch_grid_counter #(.PH(PH), .PW(PW)) u_grid (
    .clk     (clk),
    .reset   (reset),
    .clear_i (grid_clear),
    .step_i  (grid_step),
    .row_o   (grid_row),
    .col_o   (grid_col),
    .idx_o   (grid_idx),
    .last_o  (grid_last)
  );

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    error_d    = error_q;
    pf_en_d    = 1'b0;
    grid_clear = 1'b0;
    grid_step  = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        state_d    = S_LOAD;
        grid_clear = 1'b1;
        error_d    = 1'b0;
      end
      S_LOAD: if (bus.load_ack) state_d = S_KICK;
      // A stale DONE or busy patchifier keeps us here until it reports IDLE.
      S_KICK: if (bus.pf_state == PF_IDLE) begin
        state_d = S_WAIT_PF;
        pf_en_d = 1'b1;
      end
      S_WAIT_PF: begin
        if (bus.pf_state == PF_DONE) begin
          state_d = S_SETTLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      // The patchifier registers its vector on the first DONE cycle.
      S_SETTLE: state_d = S_EMIT;
      S_EMIT: if (bus.out_ready) begin
        if (grid_last) begin
          state_d = S_FINISH;
        end else begin
          state_d   = S_LOAD;
          grid_step = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are glitch-free registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      error_q     <= 1'b0;
      pf_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      error_q     <= error_d;
      pf_en_q     <= pf_en_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FINISH);
      load_req_q  <= (state_d == S_LOAD);
      out_valid_q <= (state_d == S_EMIT);
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;
  assign bus.load_req        = load_req_q;
  assign bus.load_row        = grid_row;
  assign bus.load_col        = grid_col;
  assign bus.pf_en           = pf_en_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_patch_idx   = grid_idx;
  assign bus.pf_output_taken = out_valid_q & bus.out_ready;

endmodule
